// File: rtl/freq_gate_ctrl.sv
// Gate-time controller for the frequency meter: counts synchronised sig_in rising edges
// into a saturating 4-digit BCD counter over a selectable gate, then latches the result.
module freq_gate_ctrl #(
  parameter int unsigned GATE_1S = 50_000_000,
  parameter int unsigned CW      = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] range_sel,
  input  logic       sig_in,
  output logic [3:0] th_c,
  output logic [3:0] hu_c,
  output logic [3:0] ten_c,
  output logic [3:0] one_c,
  output logic [1:0] range_out,
  output logic       ovf,
  output logic       valid,
  output logic       busy
);

  localparam logic [CW-1:0] Load1   = CW'(GATE_1S - 1);
  localparam logic [CW-1:0] Load10  = CW'(GATE_1S / 10 - 1);
  localparam logic [CW-1:0] Load100 = CW'(GATE_1S / 100 - 1);

  typedef enum logic [1:0] {StIdle, StGate, StLatch, StClear} state_e;

  state_e          state_q;
  logic            sync1_q, sync2_q, sync3_q;
  logic            sig_rise;
  logic [3:0][3:0] cnt_q;
  logic [3:0][3:0] cnt_inc;
  logic            cnt_full;
  logic            carry;
  logic            ovf_cnt_q;
  logic [CW-1:0]   timer_q;
  logic [CW-1:0]   gate_load;
  logic [1:0]      range_q;
  logic [1:0]      range_norm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign sig_rise = sync2_q & ~sync3_q;

  // Decade cascade: each digit wraps 9 -> 0 and passes the carry upward.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    cnt_full = (cnt_q == 16'h9999);
  end

  always_comb begin
    range_norm = (range_sel == 2'b11) ? 2'b00 : range_sel;
    case (range_norm)
      2'b01:   gate_load = Load10;
      2'b10:   gate_load = Load100;
      default: gate_load = Load1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ovf_cnt_q <= 1'b0;
      timer_q   <= '0;
      range_q   <= 2'b00;
      th_c      <= 4'd0;
      hu_c      <= 4'd0;
      ten_c     <= 4'd0;
      one_c     <= 4'd0;
      range_out <= 2'b00;
      ovf       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          ovf_cnt_q <= 1'b0;
          if (en) begin
            state_q <= StGate;
            range_q <= range_norm;
            timer_q <= gate_load;
          end
        end
        StGate: begin
          if (!en) begin
            // Abort: drop the partial count, keep the previously latched result.
            state_q   <= StIdle;
            cnt_q     <= '0;
            ovf_cnt_q <= 1'b0;
          end else begin
            if (sig_rise) begin
              if (cnt_full) ovf_cnt_q <= 1'b1;
              else          cnt_q     <= cnt_inc;
            end
            if (timer_q == '0) state_q <= StLatch;
            else               timer_q <= timer_q - CW'(1);
          end
        end
        StLatch: begin
          {th_c, hu_c, ten_c, one_c} <= cnt_q;
          ovf       <= ovf_cnt_q;
          range_out <= range_q;
          valid     <= 1'b1;
          state_q   <= StClear;
        end
        StClear: begin
          cnt_q     <= '0;
          ovf_cnt_q <= 1'b0;
          if (en) begin
            state_q <= StGate;
            range_q <= range_norm;
            timer_q <= gate_load;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule
